// File: rtl/seven_seg_pkg.sv
// Shared constants, digit select type and hex-to-segment helper for the
// seven_seg_scan display driver.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;
    localparam int         NUM_DIGITS = 4;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef logic [1:0] digit_sel_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Decode the selected nibble into segment drive
    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seven_seg_scan.sv
// 4-digit common-anode scan driver with blink phase generation.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blank_mask,
    input  logic        blink_en,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        decimal_p,
    output logic        blink,
    output logic        digit_tick
);

    localparam int REFRESH_W = $clog2(REFRESH_DIV);
    localparam int BLINK_W   = $clog2(BLINK_DIV);
    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_DIV - 1);

    logic [REFRESH_W-1:0] refresh_cnt_r;
    logic [BLINK_W-1:0]   blink_cnt_r;
    digit_sel_t           digit_sel_r;

    logic       refresh_wrap_s;
    logic       blink_wrap_s;
    logic [3:0] nibble_s;
    logic [3:0] digit_onehot_s;
    logic [3:0] suppress_s;
    logic [6:0] dec_seg_s;
    logic [3:0] anode_s;
    logic [6:0] seg_s;
    logic       decimal_p_s;

    assign refresh_wrap_s = (refresh_cnt_r == REFRESH_LAST);
    assign blink_wrap_s   = (blink_cnt_r == BLINK_LAST);

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is suppressed when it and every digit to its left are zero
    assign suppress_s = {value[15:12] == 4'd0, value[15:8] == 8'd0,
                         value[15:4] == 12'd0, 1'b0};
`else
    assign suppress_s = 4'b0000;
`endif

    // Select the nibble and one-hot anode position for the active digit
    always_comb begin
        digit_onehot_s = 4'b0001 << digit_sel_r;
        case (digit_sel_r)
            2'd0:    nibble_s = value[3:0];
            2'd1:    nibble_s = value[7:4];
            2'd2:    nibble_s = value[11:8];
            2'd3:    nibble_s = value[15:12];
            default: nibble_s = value[3:0];
        endcase
    end

    seg_hex_decoder u_dec (
        .hex (nibble_s),
        .seg (dec_seg_s)
    );

    // Next output drive: blank overrides suppression, which keeps only a lit dp
    always_comb begin
        anode_s     = ANODE_OFF;
        seg_s       = SEG_BLANK;
        decimal_p_s = 1'b1;
        if (blank_mask[digit_sel_r]) begin
            anode_s     = ANODE_OFF;
            seg_s       = SEG_BLANK;
            decimal_p_s = 1'b1;
        end else if (suppress_s[digit_sel_r]) begin
            if (dp_mask[digit_sel_r]) begin
                anode_s     = ~digit_onehot_s;
                seg_s       = SEG_BLANK;
                decimal_p_s = 1'b0;
            end else begin
                anode_s     = ANODE_OFF;
                seg_s       = SEG_BLANK;
                decimal_p_s = 1'b1;
            end
        end else begin
            anode_s     = ~digit_onehot_s;
            seg_s       = dec_seg_s;
            decimal_p_s = ~dp_mask[digit_sel_r];
        end
    end

    // Refresh divider and digit scan position
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_r <= '0;
            digit_sel_r   <= 2'd0;
            digit_tick    <= 1'b0;
        end else begin
            digit_tick <= refresh_wrap_s;
            if (refresh_wrap_s) begin
                refresh_cnt_r <= '0;
                digit_sel_r   <= digit_sel_r + 2'd1;
            end else begin
                refresh_cnt_r <= refresh_cnt_r + REFRESH_W'(1);
            end
        end
    end

    // Blink phase; disabled blink parks the counter so re-enable starts a full on-phase
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_r <= '0;
            blink       <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt_r <= '0;
            blink       <= 1'b1;
        end else if (blink_wrap_s) begin
            blink_cnt_r <= '0;
            blink       <= ~blink;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
    end

    // Register display drive from the live inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            anode     <= ANODE_OFF;
            seg       <= SEG_BLANK;
            decimal_p <= 1'b1;
        end else begin
            anode     <= anode_s;
            seg       <= seg_s;
            decimal_p <= decimal_p_s;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed self-checking bench for seven_seg_scan (REFRESH_DIV=4, BLINK_DIV=10).
module tb_seven_seg_scan;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic        blink_en;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        decimal_p;
    logic        blink;
    logic        digit_tick;

    int pass_cnt;
    int total_cnt;

    logic [6:0] hex_tbl [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [3:0] an_tbl [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seven_seg_scan #(.REFRESH_DIV(4), .BLINK_DIV(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .blink_en   (blink_en),
        .anode      (anode),
        .seg        (seg),
        .decimal_p  (decimal_p),
        .blink      (blink),
        .digit_tick (digit_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [13:0] got, exp;
        reset = 1'b1; value = 16'h1234; dp_mask = 4'b0000;
        blank_mask = 4'b0000; blink_en = 1'b0;
        repeat (3) step();
        got = {anode, seg, decimal_p, blink, digit_tick};
        exp = {4'b1111, 7'b1111111, 1'b1, 1'b1, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL reset_state got=%b exp=%b", got, exp);
        else pass_cnt++;
        reset = 1'b0;
        step();
        total_cnt++;
        if ({anode, seg} !== {4'b1110, 7'b0011001})
            $display("FAIL first_digit got=%b_%b exp=1110_0011001", anode, seg);
        else pass_cnt++;
    endtask

    task automatic test_scan;
        logic [12:0] got, exp;
        int d;
        value = 16'h1234; dp_mask = 4'b0000; blank_mask = 4'b0000;
        do_reset();
        for (int k = 1; k <= 33; k++) begin
            step();
            d = ((k - 1) / 4) % 4;
            got = {anode, seg, decimal_p, digit_tick};
            exp = {an_tbl[d], hex_tbl[4 - d], 1'b1, (k % 4 == 0)};
            total_cnt++;
            if (got !== exp) $display("FAIL scan k=%0d got=%b exp=%b", k, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_blank_dp;
        logic [12:0] got, exp;
        int d;
        value = 16'h1234; dp_mask = 4'b0100; blank_mask = 4'b0001;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step();
            d = ((k - 1) / 4) % 4;
            got = {anode, seg, decimal_p, digit_tick};
            if (d == 0) exp = {4'b1111, 7'b1111111, 1'b1, (k % 4 == 0)};
            else exp = {an_tbl[d], hex_tbl[4 - d], (d != 2), (k % 4 == 0)};
            total_cnt++;
            if (got !== exp) $display("FAIL blank_dp k=%0d got=%b exp=%b", k, got, exp);
            else pass_cnt++;
        end
        dp_mask = 4'b0000; blank_mask = 4'b0000;
    endtask

    task automatic test_blink;
        logic exp;
        value = 16'h1234;
        do_reset();
        blink_en = 1'b1;
        total_cnt++;
        if (blink !== 1'b1) $display("FAIL blink_k0 got=%b exp=1", blink);
        else pass_cnt++;
        for (int k = 1; k <= 35; k++) begin
            step();
            exp = ((k / 10) % 2 == 0);
            total_cnt++;
            if ({blink, digit_tick} !== {exp, (k % 4 == 0)})
                $display("FAIL blink k=%0d got=%b%b exp=%b%b", k, blink, digit_tick, exp, (k % 4 == 0));
            else pass_cnt++;
        end
        blink_en = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            step();
            total_cnt++;
            if (blink !== 1'b1) $display("FAIL blink_hold k=%0d got=%b exp=1", k, blink);
            else pass_cnt++;
        end
        blink_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp = (k < 10);
            total_cnt++;
            if (blink !== exp) $display("FAIL blink_reen k=%0d got=%b exp=%b", k, blink, exp);
            else pass_cnt++;
        end
        blink_en = 1'b0;
    endtask

    task automatic test_value_change;
        value = 16'hABCD;
        do_reset();
        repeat (9) step();
        total_cnt++;
        if ({anode, seg} !== {4'b1011, 7'b0000011})
            $display("FAIL chg_before got=%b_%b exp=1011_0000011", anode, seg);
        else pass_cnt++;
        value = 16'hEF01;
        step();
        total_cnt++;
        if ({anode, seg} !== {4'b1011, 7'b0001110})
            $display("FAIL chg_next got=%b_%b exp=1011_0001110", anode, seg);
        else pass_cnt++;
        repeat (3) step();
        total_cnt++;
        if ({anode, seg} !== {4'b0111, 7'b0000110})
            $display("FAIL chg_d3 got=%b_%b exp=0111_0000110", anode, seg);
        else pass_cnt++;
        repeat (4) step();
        total_cnt++;
        if ({anode, seg} !== {4'b1110, 7'b1111001})
            $display("FAIL chg_d0 got=%b_%b exp=1110_1111001", anode, seg);
        else pass_cnt++;
        repeat (4) step();
        total_cnt++;
        if ({anode, seg} !== {4'b1101, 7'b1000000})
            $display("FAIL chg_d1 got=%b_%b exp=1101_1000000", anode, seg);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        value = 16'h1234; blink_en = 1'b1;
        do_reset();
        repeat (15) step();
        reset = 1'b1;
        step();
        total_cnt++;
        if ({anode, seg, decimal_p, blink, digit_tick} !== {4'b1111, 7'b1111111, 3'b110})
            $display("FAIL mid_reset got=%b_%b_%b%b%b exp=1111_1111111_110",
                     anode, seg, decimal_p, blink, digit_tick);
        else pass_cnt++;
        reset = 1'b0;
        step();
        total_cnt++;
        if ({anode, digit_tick} !== {4'b1110, 1'b0})
            $display("FAIL mid_release got=%b_%b exp=1110_0", anode, digit_tick);
        else pass_cnt++;
        repeat (3) step();
        total_cnt++;
        if ({anode, digit_tick} !== {4'b1110, 1'b1})
            $display("FAIL mid_tick got=%b_%b exp=1110_1", anode, digit_tick);
        else pass_cnt++;
        blink_en = 1'b0;
    endtask

    task automatic test_decode;
        for (int n = 0; n < 16; n++) begin
            value = 16'(n);
            do_reset();
            step();
            total_cnt++;
            if ({anode, seg} !== {4'b1110, hex_tbl[n]})
                $display("FAIL decode n=%0d got=%b_%b exp=1110_%b", n, anode, seg, hex_tbl[n]);
            else pass_cnt++;
        end
    endtask

    task automatic test_leading_zero;
        logic [11:0] got, exp;
        value = 16'h0050; dp_mask = 4'b0000; blank_mask = 4'b0000;
        do_reset();
        step();
        got = {anode, seg, decimal_p};
        exp = {4'b1110, 7'b1000000, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL lzb_d0 got=%b exp=%b", got, exp);
        else pass_cnt++;
        repeat (4) step();
        got = {anode, seg, decimal_p};
        exp = {4'b1101, 7'b0010010, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL lzb_d1 got=%b exp=%b", got, exp);
        else pass_cnt++;
        repeat (4) step();
        got = {anode, seg, decimal_p};
`ifdef LEADING_ZERO_BLANK_EN
        exp = {4'b1111, 7'b1111111, 1'b1};
`else
        exp = {4'b1011, 7'b1000000, 1'b1};
`endif
        total_cnt++;
        if (got !== exp) $display("FAIL lzb_d2 got=%b exp=%b", got, exp);
        else pass_cnt++;
        repeat (4) step();
        got = {anode, seg, decimal_p};
`ifdef LEADING_ZERO_BLANK_EN
        exp = {4'b1111, 7'b1111111, 1'b1};
`else
        exp = {4'b0111, 7'b1000000, 1'b1};
`endif
        total_cnt++;
        if (got !== exp) $display("FAIL lzb_d3 got=%b exp=%b", got, exp);
        else pass_cnt++;
        dp_mask = 4'b1000;
        step();
        got = {anode, seg, decimal_p};
`ifdef LEADING_ZERO_BLANK_EN
        exp = {4'b0111, 7'b1111111, 1'b0};
`else
        exp = {4'b0111, 7'b1000000, 1'b0};
`endif
        total_cnt++;
        if (got !== exp) $display("FAIL lzb_dp got=%b exp=%b", got, exp);
        else pass_cnt++;
        blank_mask = 4'b1000;
        step();
        got = {anode, seg, decimal_p};
        exp = {4'b1111, 7'b1111111, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL lzb_blank got=%b exp=%b", got, exp);
        else pass_cnt++;
        dp_mask = 4'b0000; blank_mask = 4'b0000;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_scan();
        test_blank_dp();
        test_blink();
        test_value_change();
        test_reset_mid();
        test_decode();
        test_leading_zero();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
